uart_rx_oversampled: RTL and testbench

- Serial receiver front end of the UART core. It sits directly upstream of the RX FIFO, which feeds the operand/opcode interface and the ALU.
- Synchronises the asynchronous RsRx line, detects start bits and samples each data bit at mid-bit using the 16x oversampling tick from the baud generator.
- Presents each assembled byte with a one-cycle done strobe, plus a framing-error flag for the FIFO write side.

---
 rtl/uart_rx_oversampled.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampled.sv
// UART receiver front end: synchronises rx, finds start bits, samples each
// data bit at mid-bit on the 16x s_tick, and strobes the assembled word.
// Latency: SYNC_STAGES clk line-to-FSM; strobe one clk after the final stop tick.
// Backpressure: none; rx_done_tick is never stalled and the consumer must take or drop the word.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   rx           raw serial line (idle high, asynchronous to clk)
//   s_tick       one-clk pulse at 16x the baud rate
//   dout         last received data word, LSB received first
//   rx_done_tick one-clk pulse: dout and frame_err are valid
//   frame_err    stop bit was sampled low on the frame just completed
//   busy         receiver is in any state other than IDLE
module uart_rx_oversampled #(
  parameter int DBIT        = 8,
  parameter int SB_TICK     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            busy
);

  localparam int SMAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_MID      = SW'(7);
  localparam logic [SW-1:0] S_BIT_END  = SW'(15);
  localparam logic [SW-1:0] S_STOP_END = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [SW-1:0]          s_q, s_d;
  logic [NW-1:0]          n_q, n_d;
  logic [DBIT-1:0]        b_q, b_d;
  logic                   stop_ok_q, stop_ok_d;
  logic [DBIT-1:0]        dout_q, dout_d;
  logic                   ferr_q, ferr_d;
  logic                   done_q, done_d;

  // Synchroniser resets to the idle-line level so reset release cannot
  // look like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      stop_ok_q <= 1'b0;
      dout_q    <= '0;
      ferr_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
      stop_ok_q <= stop_ok_d;
      dout_q    <= dout_d;
      ferr_q    <= ferr_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    b_d       = b_q;
    stop_ok_d = stop_ok_q;
    dout_d    = dout_q;
    ferr_d    = ferr_q;
    done_d    = 1'b0;

    case (state_q)
      // Start detection ignores s_tick; a tick coinciding with this edge
      // is deliberately not counted.
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end

      START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              // Line went back high before mid-start: treat as a glitch.
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT_END) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (s_tick) begin
          if (s_q == S_BIT_END) begin
            stop_ok_d = rx_s;
          end
          if (s_q == S_STOP_END) begin
            state_d = IDLE;
            dout_d  = b_q;
            // With a single stop bit the mid-stop sample and the end of the
            // stop period fall on the same tick, so use rx_s directly there.
            ferr_d  = ~((s_q == S_BIT_END) ? rx_s : stop_ok_q);
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign dout         = dout_q;
  assign frame_err    = ferr_q;
  assign rx_done_tick = done_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
module tb_uart_rx_oversampled;

  typedef struct {
    logic [7:0] d;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx, rx2;
  logic       s_tick;
  logic [7:0] dout, dout2;
  logic       done, done2, ferr, ferr2, busy, busy2;

  logic [1:0] tick_cnt = 2'd0;
  int         cyc = 0;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0, done2_cnt = 0;
  int last_done_cyc = 0, last_done2_cyc = 0;
  int frame_start_cyc = 0;
  int strobe_cyc_q[$];
  exp_t exp_q[$], exp2_q[$];
  exp_t e1, e2;

  always #5 clk = ~clk;
  always @(posedge clk) begin
    tick_cnt <= tick_cnt + 2'd1;
    cyc      <= cyc + 1;
  end
  assign s_tick = (tick_cnt == 2'd0);

  uart_rx_oversampled #(.DBIT(8), .SB_TICK(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick),
    .dout(dout), .rx_done_tick(done), .frame_err(ferr), .busy(busy));

  uart_rx_oversampled #(.DBIT(8), .SB_TICK(32), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .reset(reset), .rx(rx2), .s_tick(s_tick),
    .dout(dout2), .rx_done_tick(done2), .frame_err(ferr2), .busy(busy2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: pop the expected word whenever a strobe appears.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
      strobe_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e1 = exp_q.pop_front();
        chk("dout", {24'd0, dout}, {24'd0, e1.d});
        chk("frame_err", {31'd0, ferr}, {31'd0, e1.fe});
      end
      chk("busy_at_strobe", {31'd0, busy}, 32'd0);
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      done2_cnt++;
      last_done2_cyc = cyc;
      if (exp2_q.size() == 0) begin
        chk("unexpected_strobe2", 32'd1, 32'd0);
      end else begin
        e2 = exp2_q.pop_front();
        chk("dout2", {24'd0, dout2}, {24'd0, e2.d});
        chk("frame_err2", {31'd0, ferr2}, {31'd0, e2.fe});
      end
    end
  end

  task automatic drive(input bit line2, input logic v);
    if (line2) rx2 = v;
    else       rx  = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Caller must be at a negedge; aligns the frame start to a tick edge.
  task automatic sync_tick();
    while (!s_tick) @(negedge clk);
  endtask

  // One frame, 64 clk (16 ticks) per bit. A bad stop bit is held low only
  // past its mid-point so the trailing low does not start a real frame.
  task automatic send(input logic [7:0] d, input bit stop_bad, input bit line2);
    exp_t e;
    e.d  = d;
    e.fe = stop_bad;
    if (line2) exp2_q.push_back(e);
    else       exp_q.push_back(e);
    sync_tick();
    frame_start_cyc = cyc;
    drive(line2, 1'b0);
    idle(64);
    for (int i = 0; i < 8; i++) begin
      drive(line2, d[i]);
      idle(64);
    end
    if (stop_bad) begin
      drive(line2, 1'b0);
      idle(40);
      drive(line2, 1'b1);
      idle(24);
    end else begin
      drive(line2, 1'b1);
      idle(64);
    end
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, done_cnt, target);
  endtask

  initial begin
    logic [7:0] v55;
    reset = 1'b0;
    rx    = 1'b1;
    rx2   = 1'b1;
    idle(5);
    chk("rst_dout", {24'd0, dout}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ferr", {31'd0, ferr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    idle(10);

    // 1: clean 0xA5, one stop bit
    send(8'hA5, 1'b0, 1'b0);
    wait_done(1, 800, "t1_strobe_count");
    chk("t1_latency", last_done_cyc - frame_start_cyc, 609);
    chk("t1_busy_after", {31'd0, busy}, 32'd0);

    // 2: 5-tick glitch rejected at mid-start
    idle(64);
    sync_tick();
    rx = 1'b0;
    idle(20);
    chk("t2_busy_during", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    idle(200);
    chk("t2_busy_after", {31'd0, busy}, 32'd0);
    chk("t2_dout_held", {24'd0, dout}, 32'hA5);
    chk("t2_no_strobe", done_cnt, 1);

    // 3: framing error, then a clean frame clears the flag
    send(8'h3C, 1'b1, 1'b0);
    idle(128);
    send(8'h81, 1'b0, 1'b0);
    wait_done(3, 800, "t3_strobe_count");

    // 4: back-to-back 0x00, 0xFF
    idle(64);
    strobe_cyc_q.delete();
    send(8'h00, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b0);
    wait_done(5, 800, "t4_strobe_count");
    if (strobe_cyc_q.size() >= 2)
      chk("t4_spacing", strobe_cyc_q[1] - strobe_cyc_q[0], 640);
    else
      chk("t4_spacing_count", strobe_cyc_q.size(), 2);

    // 5: reset during 4th data bit of 0x55
    idle(64);
    v55 = 8'h55;
    sync_tick();
    rx = 1'b0;
    idle(64);
    for (int i = 0; i < 3; i++) begin
      rx = v55[i];
      idle(64);
    end
    rx = v55[3];
    idle(30);
    reset = 1'b0;
    #1;
    chk("t5_rst_dout", {24'd0, dout}, 32'd0);
    chk("t5_rst_done", {31'd0, done}, 32'd0);
    chk("t5_rst_ferr", {31'd0, ferr}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    idle(8);
    reset = 1'b1;
    idle(64);
    chk("t5_no_partial_strobe", done_cnt, 5);
    send(8'h55, 1'b0, 1'b0);
    wait_done(6, 800, "t5_strobe_count");

    // 6: two stop bits on the SB_TICK=32 instance
    idle(64);
    send(8'h7E, 1'b0, 1'b1);
    begin
      int k = 0;
      while (done2_cnt < 1 && k < 800) begin
        @(negedge clk);
        k++;
      end
    end
    chk("t6_strobe_count", done2_cnt, 1);
    chk("t6_latency", last_done2_cyc - frame_start_cyc, 673);
    idle(20);

    chk("sb_empty", exp_q.size(), 0);
    chk("sb2_empty", exp2_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
